sum8_lookahead: RTL and testbench
=================================

Name: sum8_lookahead

Overview:
- Registered 8-bit carry-lookahead adder for the adder power-analysis suite.
- Computes A + B + Cin using two 4-bit lookahead groups.
- Registers the 9-bit result.
- Keeps an internal 32-bit transition counter on its registered outputs. The bench reads this counter to compare switching activity against other adder architectures.

Parameters:
- PWR_CNTR_ID, default 0: index of this adder's transition counter in the bench counter bank. Reflected unchanged on output cntr_id; no effect on arithmetic.
- CNT_W, default 32: width of the transition counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid this cycle.
- opr_a  in  8  operand A, unsigned.
- opr_b  in  8  operand B, unsigned.
- cin  in  1  carry in.
- suma  out  8  registered sum bits.
- cout  out  1  registered carry out.
- out_valid  out  1  suma/cout updated from a valid input.
- trans_cnt  out  CNT_W  accumulated output bit transitions.
- cntr_clr  in  1  synchronous clear of trans_cnt only.
- cntr_id  out  2  constant PWR_CNTR_ID (truncated to 2 bits).

Behaviour:
- Combinational core, per bit i:
  - g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Group 0 (bits 3:0), carries fully expanded, no ripple:
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 and c4 follow the same pattern.
- Group 1 (bits 7:4):
  - Group generate/propagate: GG0 = g3|p3g2|p3p2g1|p3p2p1g0; GP0 = p3p2p1p0.
  - Group 1 carry-in = GG0 | GP0·cin.
  - Internal carries formed the same way; cout = GG1 | GP1·c4.
- sum[i] = p[i] ^ c[i].
- Functional requirement: {cout, sum} == opr_a + opr_b + cin for all 2^17 input combinations.
- Latency: result registered exactly 1 clk after the in_valid edge.
  - in_valid=1 at edge N → suma/cout/out_valid show the result after edge N.
  - in_valid=0 → suma/cout hold; out_valid=0.
- Transition counter:
  - On every edge where in_valid=1 (and not reset), trans_cnt += popcount({cout_next,sum_next} XOR {cout,suma}).
  - Range 0..9 per cycle.
  - Saturates at all-ones; no wrap.
- cntr_clr=1 clears trans_cnt to 0 at the edge.
  - No increment in that cycle.
  - suma/cout still update normally.
- Reset (synchronous, high): suma=0, cout=0, out_valid=0, trans_cnt=0.
  - Reset has priority over in_valid and cntr_clr.
  - Reset mid-stream discards any in-flight result.
  - The first valid result after reset counts transitions from 0.
- No handshake back-pressure: the block accepts one operand pair every cycle.

Decomposition:
- Package sum8_pkg holds:
  - constants WIDTH=8, GROUP_W=4, CNT_W_DEFAULT=32;
  - a popcount9 function.
- One sub-module, cla4_group: inputs a[3:0], b[3:0], cin; outputs sum[3:0], group generate GG, group propagate GP, cout. Instantiated twice.
- Top level does:
  - the inter-group carry;
  - output registers;
  - the transition counter.

Test Plan:
- Reset then idle: assert reset 2 cycles → suma=0, cout=0, out_valid=0, trans_cnt=0; holds while in_valid=0.
- Carry chain: 255+1, cin=0 → suma=0, cout=1 next cycle. Then 200+100, cin=0 → suma=44, cout=1. Then 127+127, cin=1 → suma=255, cout=0.
- Transition count: after reset, apply 255+0 → suma=255, trans_cnt=8. Then 0+0 → suma=0, trans_cnt=16. Then 0+0 again → trans_cnt=16. Then 128+128 → suma=0, cout=1, trans_cnt=17.
- Clear/reset priority: drive cntr_clr=1 with a valid 1+1 → trans_cnt=0, suma=2. Reset asserted together with in_valid=1, 5+5 → suma=0, out_valid=0.
- Random regression: 100 vectors from seed 10, in_valid held 1 → every cycle {cout,suma} equals the previous cycle's opr_a+opr_b+cin. trans_cnt equals the scoreboard Hamming-distance sum.
- Saturation: force trans_cnt to all-ones minus 3 (CNT_W=32 via hierarchical deposit), then apply a 9-bit toggle → trans_cnt=0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/sum8_pkg.sv
// Shared constants and helpers for the registered 8-bit lookahead adder.
// Imported by the group sub-module and the top level.
package sum8_pkg;

    localparam int WIDTH         = 8;
    localparam int GROUP_W       = 4;
    localparam int CNT_W_DEFAULT = 32;

    // Number of set bits in a 9-bit vector; result range is 0..9.
    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sum8_lookahead_cla4_group.sv
// 4-bit carry-lookahead group: every internal carry is expanded directly from
// g/p and the group carry-in, so no carry ripples through the group.
module cla4_group
    import sum8_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               gg,
    output logic               gp,
    output logic               cout
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    // Group terms are independent of cin so the next group can look ahead.
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

    assign cout = gg | (gp & cin);
    assign sum  = p ^ c;

endmodule

// File: rtl/sum8_lookahead.sv
// Registered 8-bit carry-lookahead adder with a saturating counter of output
// bit transitions used for switching-activity comparisons.
module sum8_lookahead
    import sum8_pkg::*;
#(
    parameter int PWR_CNTR_ID = 0,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opr_a,
    input  logic [WIDTH-1:0] opr_b,
    input  logic             cin,
    output logic [WIDTH-1:0] suma,
    output logic             cout,
    output logic             out_valid,
    output logic [CNT_W-1:0] trans_cnt,
    input  logic             cntr_clr,
    output logic [1:0]       cntr_id
);

    logic [GROUP_W-1:0] sum_lo;
    logic [GROUP_W-1:0] sum_hi;
    logic               gg0, gp0, gg1, gp1;
    logic               grp0_cout, grp1_cout;
    logic               c4;
    logic               cout_next;
    logic [WIDTH:0]     res_next;

    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_next;

    cla4_group u_grp0 (
        .a    (opr_a[GROUP_W-1:0]),
        .b    (opr_b[GROUP_W-1:0]),
        .cin  (cin),
        .sum  (sum_lo),
        .gg   (gg0),
        .gp   (gp0),
        .cout (grp0_cout)
    );

    // Inter-group carry comes from group 0's generate/propagate, not its ripple.
    assign c4 = gg0 | (gp0 & cin);

    cla4_group u_grp1 (
        .a    (opr_a[WIDTH-1:GROUP_W]),
        .b    (opr_b[WIDTH-1:GROUP_W]),
        .cin  (c4),
        .sum  (sum_hi),
        .gg   (gg1),
        .gp   (gp1),
        .cout (grp1_cout)
    );

    assign cout_next = gg1 | (gp1 & c4);
    assign res_next  = {cout_next, sum_hi, sum_lo};

    // The groups' own carry-outs must agree with the lookahead terms.
    assert property (@(posedge clk) (grp0_cout == c4) && (grp1_cout == cout_next));

    // Widen by one bit so overflow of the accumulation is visible for saturation.
    always_comb begin
        cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(popcount9(res_next ^ {cout_q, sum_q}));
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= res_next[WIDTH-1:0];
                cout_q <= res_next[WIDTH];
            end
            if (cntr_clr) begin
                cnt_q <= '0;
            end else if (in_valid) begin
                cnt_q <= cnt_next;
            end
        end
    end

    assign suma      = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
    assign trans_cnt = cnt_q;
    assign cntr_id   = 2'(PWR_CNTR_ID);

endmodule

// File: tb/tb_sum8_lookahead.sv
// Self-checking bench for sum8_lookahead: directed carry/counter/priority cases,
// seeded random regression against an arithmetic model, and counter saturation.
module tb_sum8_lookahead;

    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  opr_a;
    logic [7:0]  opr_b;
    logic        cin;
    logic        cntr_clr;
    logic [7:0]  suma;
    logic        cout;
    logic        out_valid;
    logic [31:0] trans_cnt;
    logic [1:0]  cntr_id;

    int n_tests;
    int n_fail;

    // Reference model state: last registered 9-bit result, valid flag, counter.
    int     m_res;
    bit     m_valid;
    longint m_cnt;

    sum8_lookahead #(.PWR_CNTR_ID(0), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .cin       (cin),
        .suma      (suma),
        .cout      (cout),
        .out_valid (out_valid),
        .trans_cnt (trans_cnt),
        .cntr_clr  (cntr_clr),
        .cntr_id   (cntr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int hamming9(input int x, input int y);
        int d;
        int n;
        d = (x ^ y) & 9'h1FF;
        n = 0;
        while (d != 0) begin
            n = n + (d & 1);
            d = d >> 1;
        end
        return n;
    endfunction

    // One clock: drive inputs, let the edge happen, update the model, compare.
    task automatic step(input bit v, input int a, input int b, input bit c,
                        input bit clr, input bit rst, input string tag);
        int sum_full;
        @(negedge clk);
        in_valid = v;
        opr_a    = 8'(a);
        opr_b    = 8'(b);
        cin      = c;
        cntr_clr = clr;
        reset    = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_res   = 0;
            m_valid = 0;
            m_cnt   = 0;
        end else begin
            m_valid = v;
            sum_full = a + b + int'(c);
            if (clr) begin
                m_cnt = 0;
            end else if (v) begin
                m_cnt = m_cnt + hamming9(sum_full, m_res);
                if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            end
            if (v) m_res = sum_full;
        end
        check({tag, ".suma"},      64'(suma),      64'(m_res & 8'hFF));
        check({tag, ".cout"},      64'(cout),      64'((m_res >> 8) & 1));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".trans_cnt"}, 64'(trans_cnt), 64'(m_cnt));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_res    = 0;
        m_valid  = 0;
        m_cnt    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        opr_a    = '0;
        opr_b    = '0;
        cin      = 1'b0;
        cntr_clr = 1'b0;

        // Reset for two cycles, then idle.
        step(0, 0, 0, 0, 0, 1, "rst0");
        step(0, 0, 0, 0, 0, 1, "rst1");
        check("rst.trans_cnt_zero", 64'(trans_cnt), 64'd0);
        check("cntr_id", 64'(cntr_id), 64'd0);
        step(0, 0, 0, 0, 0, 0, "idle0");
        step(0, 0, 0, 0, 0, 0, "idle1");
        check("idle.suma_zero", 64'(suma), 64'd0);

        // Carry chain through both groups.
        step(1, 255, 1, 0, 0, 0, "c255p1");
        check("c255p1.const", 64'({cout, suma}), 64'h100);
        step(1, 200, 100, 0, 0, 0, "c200p100");
        check("c200p100.const", 64'({cout, suma}), 64'h12C);
        step(1, 127, 127, 1, 0, 0, "c127p127c");
        check("c127p127c.const", 64'({cout, suma}), 64'h0FF);
        // Hold with in_valid low: outputs keep the last result.
        step(0, 3, 4, 1, 0, 0, "hold");
        check("hold.const", 64'({cout, suma}), 64'h0FF);

        // Transition counting from a fresh reset.
        step(0, 0, 0, 0, 0, 1, "rst2");
        step(1, 255, 0, 0, 0, 0, "t255");
        check("t255.cnt_const", 64'(trans_cnt), 64'd8);
        step(1, 0, 0, 0, 0, 0, "t0a");
        check("t0a.cnt_const", 64'(trans_cnt), 64'd16);
        step(1, 0, 0, 0, 0, 0, "t0b");
        check("t0b.cnt_const", 64'(trans_cnt), 64'd16);
        step(1, 128, 128, 0, 0, 0, "t128");
        check("t128.cnt_const", 64'(trans_cnt), 64'd17);
        check("t128.cout_const", 64'(cout), 64'd1);

        // Clear beats increment; reset beats a valid operand pair.
        step(1, 1, 1, 0, 1, 0, "clr");
        check("clr.cnt_const", 64'(trans_cnt), 64'd0);
        check("clr.suma_const", 64'(suma), 64'd2);
        step(1, 5, 5, 0, 0, 1, "rst_vs_valid");
        check("rst_vs_valid.suma_const", 64'(suma), 64'd0);
        check("rst_vs_valid.ov_const", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0, "post_rst");

        // Seeded random regression, in_valid held high.
        void'($urandom(10));
        for (int i = 0; i < 100; i++) begin
            step(1, int'($urandom_range(255)), int'($urandom_range(255)),
                 bit'($urandom_range(1)), 0, 0, "rand");
        end

        // Saturation: deposit near-full count, then toggle all 9 output bits.
        step(1, 0, 0, 0, 0, 0, "sat_zero");
        dut.cnt_q = 32'hFFFF_FFFC;
        m_cnt     = 64'h0000_0000_FFFF_FFFC;
        step(1, 255, 255, 1, 0, 0, "sat_up");
        check("sat_up.cnt_const", 64'(trans_cnt), 64'hFFFF_FFFF);
        step(1, 0, 0, 0, 0, 0, "sat_hold");
        check("sat_hold.cnt_const", 64'(trans_cnt), 64'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
